dual_port_ram_ctrl: RTL and testbench

//   Parametrised two-port RAM, successor to the 16x8 shared-data dual-address RAM.

---
 rtl/dpram_pkg.sv | 14 +
 rtl/dpram_init_seq.sv | 61 ++++++
 rtl/dual_port_ram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dual_port_ram_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM controller.
//   - default data/address widths
//   - controller state type (exported on the debug state output)
package dpram_pkg;

  localparam int DPRAM_DATA_W = 8;
  localparam int DPRAM_ADDR_W = 4;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dpram_state_t;

endpackage

// File: rtl/dpram_init_seq.sv
// Clear sequencer for the dual-port RAM array.
// Walks a pointer over addresses 0..DEPTH-1, one word per cycle. While it
// runs it owns the array's internal write port and the array is zeroed.
// Asserting clr (at any time) or rst restarts the walk at address 0.
//
// Ports:
//   clk     in   clock, posedge
//   rst     in   asynchronous active-high reset
//   clr     in   restart the clear walk
//   busy_o  out  1 while the clear walk is running
//   we_o    out  internal write enable (writes zero)
//   addr_o  out  internal write address (the clear pointer)
module dpram_init_seq #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  always_comb begin
    ptr_d  = ptr_q;
    done_d = done_q;
    if (clr) begin
      ptr_d  = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      // The cycle that writes the last word is the final busy cycle.
      if (ptr_q == LAST_ADDR) begin
        ptr_d  = '0;
        done_d = 1'b1;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      done_q <= done_d;
    end
  end

  assign busy_o = ~done_q;
  assign we_o   = ~done_q;
  assign addr_o = ptr_q;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Parametrised two-port RAM with hardware clear, same-address write
// arbitration (port 0 wins) and a saturating collision counter.
//
// Handshake: a port request is taken on a rising edge when en_x && ready
// and clr is low; there is no back-pressure beyond ready. A taken read
// updates rdata_x at that edge and rvalid_x is high for exactly the
// following cycle; rdata_x holds between reads.
//
// Optional build macro RD_FWD_EN: when defined, a read of an address being
// written in the same cycle returns the new data (write-first); otherwise
// the pre-write contents (read-first).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   clr                    pulse: re-zero the whole array
//   en_x, we_x             port request / write select
//   addr_x, wdata_x        word address / write data
//   rdata_x, rvalid_x      registered read data / one-cycle valid strobe
//   ready                  requests accepted this cycle
//   init_busy              clear sequence running
//   collision_cnt          saturating count of same-address dual writes
//   state_dbg              controller state (debug)
module dual_port_ram_ctrl
  import dpram_pkg::*;
#(
  parameter int DATA_W = DPRAM_DATA_W,
  parameter int ADDR_W = DPRAM_ADDR_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en_0,
  input  logic              en_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic              ready,
  output logic              init_busy,
  output logic [CNT_W-1:0]  collision_cnt,
  output dpram_state_t      state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              seq_busy;
  logic              seq_we;
  logic [ADDR_W-1:0] seq_addr;

  dpram_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .busy_o (seq_busy),
    .we_o   (seq_we),
    .addr_o (seq_addr)
  );

  assign ready     = ~seq_busy;
  assign init_busy = seq_busy;
  assign state_dbg = seq_busy ? ST_INIT : ST_READY;

  // Request qualification; clr drops everything in its cycle.
  logic acc_0, acc_1, in_rng_0, in_rng_1, same_addr;
  logic wr_0, wr_1, wr_1_eff, rd_0, rd_1, coll;

  assign acc_0     = en_0 & ready & ~clr;
  assign acc_1     = en_1 & ready & ~clr;
  assign in_rng_0  = ({1'b0, addr_0} < DEPTH_L);
  assign in_rng_1  = ({1'b0, addr_1} < DEPTH_L);
  assign same_addr = (addr_0 == addr_1);
  assign wr_0      = acc_0 & we_0 & in_rng_0;
  assign wr_1      = acc_1 & we_1 & in_rng_1;
  assign rd_0      = acc_0 & ~we_0;
  assign rd_1      = acc_1 & ~we_1;
  assign coll      = wr_0 & wr_1 & same_addr;
  assign wr_1_eff  = wr_1 & ~coll;  // port 0 owns a contested address

  // Array: clear sequencer and ports never write in the same cycle.
  always_ff @(posedge clk) begin
    if (seq_we) begin
      mem_q[seq_addr] <= '0;
    end else begin
      if (wr_1_eff) mem_q[addr_1] <= wdata_1;
      if (wr_0)     mem_q[addr_0] <= wdata_0;
    end
  end

  // Read values; out-of-range reads return zero.
  logic [DATA_W-1:0] rd_val_0, rd_val_1;

  always_comb begin
    rd_val_0 = '0;
    rd_val_1 = '0;
    if (in_rng_0) begin
      rd_val_0 = mem_q[addr_0];
`ifdef RD_FWD_EN
      if (wr_1 && same_addr) rd_val_0 = wdata_1;
`endif
    end
    if (in_rng_1) begin
      rd_val_1 = mem_q[addr_1];
`ifdef RD_FWD_EN
      // Port 0 is checked last so its data wins if both ports write here.
      if (wr_1 && same_addr) rd_val_1 = wdata_1;
      if (wr_0 && same_addr) rd_val_1 = wdata_0;
`endif
    end
  end

  logic [DATA_W-1:0] rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;
  logic              rvalid_0_q, rvalid_0_d, rvalid_1_q, rvalid_1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    rdata_0_d  = rd_0 ? rd_val_0 : rdata_0_q;
    rdata_1_d  = rd_1 ? rd_val_1 : rdata_1_q;
    rvalid_0_d = rd_0;
    rvalid_1_d = rd_1;
    cnt_d      = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (coll && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_0_q  <= '0;
      rdata_1_q  <= '0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rdata_0_q  <= rdata_0_d;
      rdata_1_q  <= rdata_1_d;
      rvalid_0_q <= rvalid_0_d;
      rvalid_1_q <= rvalid_1_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rdata_0       = rdata_0_q;
  assign rdata_1       = rdata_1_q;
  assign rvalid_0      = rvalid_0_q;
  assign rvalid_1      = rvalid_1_q;
  assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
module tb_dual_port_ram_ctrl;
  import dpram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       clr = 1'b0;
  logic       en_0 = 1'b0, en_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
  logic [3:0] addr_0 = '0, addr_1 = '0;
  logic [7:0] wdata_0 = '0, wdata_1 = '0;
  logic [7:0] rdata_0, rdata_1, collision_cnt;
  logic       rvalid_0, rvalid_1, ready, init_busy;
  dpram_state_t state_dbg;

  dual_port_ram_ctrl dut (
    .clk(clk), .rst(rst), .clr(clr),
    .en_0(en_0), .en_1(en_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .ready(ready), .init_busy(init_busy), .collision_cnt(collision_cnt),
    .state_dbg(state_dbg)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Behaviour in plain terms: a word array, an init countdown, a
  // saturating count. Reads return the array before (read-first) or
  // after (write-first) this cycle's writes.
  logic [7:0] m_mem [16];
  int         m_left;
  logic [7:0] m_cnt, m_rd0, m_rd1;
  logic       m_rv0, m_rv1;

  task automatic model_reset();
    m_left = 16; m_cnt = 0; m_rd0 = 0; m_rd1 = 0; m_rv0 = 0; m_rv1 = 0;
  endtask

  task automatic model_step();
    logic [7:0] old_mem [16];
    m_rv0 = 0;
    m_rv1 = 0;
    if (clr) begin
      m_left = 16;
      m_cnt  = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      old_mem = m_mem;
      if (en_1 && we_1) m_mem[addr_1] = wdata_1;
      if (en_0 && we_0) m_mem[addr_0] = wdata_0;
      if (en_0 && we_0 && en_1 && we_1 && addr_0 == addr_1 && m_cnt != 8'hFF) m_cnt++;
      m_rv0 = en_0 && !we_0;
      m_rv1 = en_1 && !we_1;
`ifdef RD_FWD_EN
      if (m_rv0) m_rd0 = m_mem[addr_0];
      if (m_rv1) m_rd1 = m_mem[addr_1];
`else
      if (m_rv0) m_rd0 = old_mem[addr_0];
      if (m_rv1) m_rd1 = old_mem[addr_1];
`endif
    end
  endtask

  task automatic check_model();
    check("ready", ready, (m_left == 0));
    check("init_busy", init_busy, (m_left > 0));
    check("state_dbg", state_dbg, (m_left == 0) ? ST_READY : ST_INIT);
    check("rvalid_0", rvalid_0, m_rv0);
    check("rvalid_1", rvalid_1, m_rv1);
    if (m_rv0) check("rdata_0", rdata_0, m_rd0);
    if (m_rv1) check("rdata_1", rdata_1, m_rd1);
    check("collision_cnt", collision_cnt, m_cnt);
  endtask

  // ---------------- driver ----------------
  // Inputs change #1 after a rising edge; outputs are sampled there too.
  task automatic cycle(input logic c, input logic e0, input logic w0, input logic [3:0] a0,
                       input logic [7:0] d0, input logic e1, input logic w1,
                       input logic [3:0] a1, input logic [7:0] d1);
    clr = c; en_0 = e0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
    en_1 = e1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0);
  endtask

  // Count cycles with init_busy high, bounded.
  task automatic count_busy(input string name);
    int n = 0;
    while (init_busy && n < 40) begin
      n++;
      idle();
    end
    check(name, n, 16);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic e0, w0; logic [3:0] a0; logic [7:0] d0;
    logic e1, w1; logic [3:0] a1; logic [7:0] d1;
    logic [7:0] x_rd0; logic x_rv0; logic [7:0] x_rd1; logic x_rv1; logic [7:0] x_cnt;
  } vec_t;
  vec_t vecs[7];

  logic [7:0] fwd_exp;

  initial begin
`ifdef RD_FWD_EN
    fwd_exp = 8'h3C;
`else
    fwd_exp = 8'h00;
`endif
    vecs[0] = '{1,1,4'd3,8'hA5, 0,0,4'd0,8'h00, 8'h00,0, 8'h00,0, 8'd0}; // P0 wr 3
    vecs[1] = '{0,0,4'd0,8'h00, 1,0,4'd3,8'h00, 8'h00,0, 8'hA5,1, 8'd0}; // P1 rd 3
    vecs[2] = '{0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 8'h00,0, 8'hA5,0, 8'd0}; // hold
    vecs[3] = '{1,1,4'd7,8'h11, 1,1,4'd7,8'h22, 8'h00,0, 8'hA5,0, 8'd1}; // collide
    vecs[4] = '{1,0,4'd7,8'h00, 0,0,4'd0,8'h00, 8'h11,1, 8'hA5,0, 8'd1}; // P0 rd 7
    vecs[5] = '{1,1,4'd5,8'h3C, 1,0,4'd5,8'h00, 8'h11,0, fwd_exp,1, 8'd1}; // rd/wr 5
    vecs[6] = '{1,0,4'd5,8'h00, 1,0,4'd5,8'h00, 8'h3C,1, 8'h3C,1, 8'd1}; // both rd 5

    // ---- reset state ----
    model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    #12;
    check("rst_rdata_0", rdata_0, 0);
    check("rst_rdata_1", rdata_1, 0);
    check("rst_rvalid", {rvalid_0, rvalid_1}, 0);
    check("rst_ready", ready, 0);
    check("rst_init_busy", init_busy, 1);
    check("rst_cnt", collision_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // The edge above was the first INIT cycle.
    model_step();
    begin
      int n = 1;
      while (init_busy && n < 40) begin
        n++;
        idle();
      end
      check("init_len_after_rst", n, 16);
    end

    // ---- all words read zero ----
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, 4'(i), 8'd0, 1, 0, 4'(15 - i), 8'd0);
      check("zero_rd0", rdata_0, 8'h00);
      check("zero_rd1", rdata_1, 8'h00);
    end

    // ---- directed table ----
    for (int i = 0; i < 7; i++) begin
      cycle(0, vecs[i].e0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
               vecs[i].e1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      check($sformatf("vec%0d_rd0", i), rdata_0, vecs[i].x_rd0);
      check($sformatf("vec%0d_rv0", i), rvalid_0, vecs[i].x_rv0);
      check($sformatf("vec%0d_rd1", i), rdata_1, vecs[i].x_rd1);
      check($sformatf("vec%0d_rv1", i), rvalid_1, vecs[i].x_rv1);
      check($sformatf("vec%0d_cnt", i), collision_cnt, vecs[i].x_cnt);
    end

    // ---- collision counter saturation ----
    for (int k = 0; k < 299; k++) begin
      logic [7:0] d;
      d = 8'(k);
      cycle(0, 1, 1, 4'd7, d, 1, 1, 4'd7, ~d);
    end
    check("cnt_saturated", collision_cnt, 8'hFF);
    cycle(0, 1, 0, 4'd7, 8'd0, 1, 0, 4'd7, 8'd0);
    check("coll_p0_wins", rdata_0, 8'(298));

    // ---- clr drops same-cycle write ----
    cycle(0, 1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'd0);
    cycle(1, 1, 1, 4'd4, 8'hFF, 0, 0, 4'd0, 8'd0);
    check("clr_busy", init_busy, 1);
    check("clr_cnt", collision_cnt, 0);
    count_busy("init_len_after_clr");
    cycle(0, 1, 0, 4'd3, 8'd0, 1, 0, 4'd4, 8'd0);
    check("clr_addr3", rdata_0, 8'h00);
    check("clr_addr4", rdata_1, 8'h00);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 600; k++) begin
      logic narrow;
      logic [3:0] a0, a1;
      narrow = ($urandom_range(0, 1) == 1);
      a0 = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      a1 = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom), a0, 8'($urandom),
            1'($urandom), 1'($urandom), a1, 8'($urandom));
    end

    // ---- rst during INIT ----
    begin
      int n = 0;
      while (!ready && n < 40) begin
        n++;
        idle();
      end
      check("ready_before_rst_test", ready, 1);
    end
    cycle(0, 1, 1, 4'd2, 8'h5A, 0, 0, 4'd0, 8'd0);
    cycle(0, 1, 0, 4'd2, 8'd0, 1, 0, 4'd2, 8'd0);
    check("pre_rst_rd0", rdata_0, 8'h5A);
    cycle(1, 0, 0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0);
    for (int k = 0; k < 4; k++) idle();
    check("clr_keeps_rdata", rdata_1, 8'h5A);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_rdata_0", rdata_0, 0);
    check("mid_rst_rdata_1", rdata_1, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_busy", init_busy, 1);
    check("mid_rst_cnt", collision_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_step();
    begin
      int n = 1;
      while (init_busy && n < 40) begin
        n++;
        idle();
      end
      check("init_len_after_mid_rst", n, 16);
    end
    cycle(0, 1, 0, 4'd2, 8'd0, 1, 0, 4'd3, 8'd0);
    check("post_rst_rd0", rdata_0, 8'h00);
    check("post_rst_rd1", rdata_1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
